// File: rtl/pwm_sample_sequencer.sv
// Sample sequencer between the IIR filter output and the pwm block.
// Buffers filtered samples in a small FIFO, primes it, starts the pwm and
// loads a new duty value on every pwm end-of-cycle pulse, tracking underruns.
module pwm_sample_sequencer #(
  parameter int unsigned N           = 31,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned PRIME_LEVEL = 2,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     sample_valid,
  input  logic [N-1:0]             sample_data,
  output logic                     sample_ready,
  input  logic                     pwm_eoc,
  output logic                     pwm_rst,
  output logic [N-1:0]             pwm_duty,
  output logic                     frame_strobe,
  output logic                     underrun,
  output logic [CNT_W-1:0]         underrun_cnt,
  input  logic                     clr_underrun,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     running
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e             state_q, state_d;
  logic [N-1:0]       mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      level_q, level_d;
  logic               pwm_rst_q, pwm_rst_d;
  logic [N-1:0]       pwm_duty_q, pwm_duty_d;
  logic               frame_strobe_q, frame_strobe_d;
  logic               underrun_q, underrun_d;
  logic [CNT_W-1:0]   underrun_cnt_q, underrun_cnt_d;
  logic               sample_ready_q, sample_ready_d;
  logic               running_q, running_d;

  logic               push, pop, eoc_fire, underrun_evt, primed;

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      level_q        <= '0;
      pwm_rst_q      <= 1'b1;
      pwm_duty_q     <= '0;
      frame_strobe_q <= 1'b0;
      underrun_q     <= 1'b0;
      underrun_cnt_q <= '0;
      sample_ready_q <= 1'b0;
      running_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      level_q        <= level_d;
      pwm_rst_q      <= pwm_rst_d;
      pwm_duty_q     <= pwm_duty_d;
      frame_strobe_q <= frame_strobe_d;
      underrun_q     <= underrun_d;
      underrun_cnt_q <= underrun_cnt_d;
      sample_ready_q <= sample_ready_d;
      running_q      <= running_d;
    end
  end

  // FIFO storage; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sample_data;
    end
  end

  assign primed = (level_q >= LW'(PRIME_LEVEL));

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:  state_d = StPrime;
        StPrime: if (primed) state_d = StRun;
        StRun:   state_d = StRun;
        default: state_d = StIdle;
      endcase
    end
  end

  // Datapath and next values of the registered outputs.
  always_comb begin
    // eoc is ignored while the pwm is held in reset (it drives eoc high then).
    eoc_fire     = enable && (state_q == StRun) && pwm_eoc && !pwm_rst_q;
    push         = enable && sample_valid && sample_ready_q;
    pop          = enable && (((state_q == StPrime) && primed) ||
                              (eoc_fire && (level_q != '0)));
    underrun_evt = eoc_fire && (level_q == '0);

    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    level_d    = level_q + LW'(push) - LW'(pop);
    pwm_rst_d  = pwm_rst_q;
    pwm_duty_d = pwm_duty_q;
    if (pop) begin
      pwm_duty_d = mem_q[rd_ptr_q];
      pwm_rst_d  = 1'b0;
    end
    frame_strobe_d = eoc_fire;

    // Disable flushes the FIFO and parks the pwm, discarding any push/pop.
    if (!enable) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      level_d    = '0;
      pwm_rst_d  = 1'b1;
      pwm_duty_d = '0;
    end

    // Clear takes priority over a coincident underrun.
    underrun_d     = underrun_q;
    underrun_cnt_d = underrun_cnt_q;
    if (clr_underrun) begin
      underrun_d     = 1'b0;
      underrun_cnt_d = '0;
    end else if (underrun_evt) begin
      underrun_d = 1'b1;
      if (underrun_cnt_q != '1) begin
        underrun_cnt_d = underrun_cnt_q + CNT_W'(1);
      end
    end

    running_d      = (state_d == StRun);
    sample_ready_d = (state_d != StIdle) && (level_d != LW'(DEPTH));
  end

  assign sample_ready = sample_ready_q;
  assign pwm_rst      = pwm_rst_q;
  assign pwm_duty     = pwm_duty_q;
  assign frame_strobe = frame_strobe_q;
  assign underrun     = underrun_q;
  assign underrun_cnt = underrun_cnt_q;
  assign level        = level_q;
  assign running      = running_q;

endmodule

// File: tb/tb_pwm_sample_sequencer.sv
// Directed table-driven bench for pwm_sample_sequencer (N=4, DEPTH=4,
// PRIME_LEVEL=2, CNT_W=2 so counter saturation is reachable quickly).
module tb_pwm_sample_sequencer;

  localparam int unsigned N     = 4;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PL    = 2;
  localparam int unsigned CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             enable;
  logic             sample_valid;
  logic [N-1:0]     sample_data;
  logic             sample_ready;
  logic             pwm_eoc;
  logic             pwm_rst;
  logic [N-1:0]     pwm_duty;
  logic             frame_strobe;
  logic             underrun;
  logic [CNT_W-1:0] underrun_cnt;
  logic             clr_underrun;
  logic [2:0]       level;
  logic             running;

  pwm_sample_sequencer #(
    .N          (N),
    .DEPTH      (DEPTH),
    .PRIME_LEVEL(PL),
    .CNT_W      (CNT_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .sample_valid(sample_valid),
    .sample_data (sample_data),
    .sample_ready(sample_ready),
    .pwm_eoc     (pwm_eoc),
    .pwm_rst     (pwm_rst),
    .pwm_duty    (pwm_duty),
    .frame_strobe(frame_strobe),
    .underrun    (underrun),
    .underrun_cnt(underrun_cnt),
    .clr_underrun(clr_underrun),
    .level       (level),
    .running     (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int en, vld, dat, eoc, clr;
    int rdy, prst, duty, stb, lvl, run, und, cnt;
  } vec_t;

  localparam int NV = 36;
  vec_t vecs [NV];
  int   n_checks;
  int   n_err;

  function automatic vec_t mk(int en, int vld, int dat, int eoc, int clr, int rdy, int prst,
                              int duty, int stb, int lvl, int run, int und, int cnt);
    vec_t v;
    v.en = en; v.vld = vld; v.dat = dat; v.eoc = eoc; v.clr = clr;
    v.rdy = rdy; v.prst = prst; v.duty = duty; v.stb = stb;
    v.lvl = lvl; v.run = run; v.und = und; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s (step %0d): got %0d, expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic chk_outputs(input int idx, input int rdy, input int prst, input int duty,
                             input int stb, input int lvl, input int run, input int und,
                             input int cnt);
    chk("sample_ready", idx, int'(sample_ready), rdy);
    chk("pwm_rst", idx, int'(pwm_rst), prst);
    chk("pwm_duty", idx, int'(pwm_duty), duty);
    chk("frame_strobe", idx, int'(frame_strobe), stb);
    chk("level", idx, int'(level), lvl);
    chk("running", idx, int'(running), run);
    chk("underrun", idx, int'(underrun), und);
    chk("underrun_cnt", idx, int'(underrun_cnt), cnt);
  endtask

  initial begin
    n_checks = 0;
    n_err    = 0;

    //               en vld dat eoc clr  rdy prst duty stb lvl run und cnt
    vecs[0]  = mk(1, 0, 0,  1, 0,   1, 1, 0,  0, 0, 0, 0, 0); // IDLE->PRIME, eoc ignored
    vecs[1]  = mk(1, 1, 3,  0, 0,   1, 1, 0,  0, 1, 0, 0, 0);
    vecs[2]  = mk(1, 1, 9,  0, 0,   1, 1, 0,  0, 2, 0, 0, 0);
    vecs[3]  = mk(1, 0, 0,  0, 0,   1, 0, 3,  0, 1, 1, 0, 0); // primed: start pwm
    vecs[4]  = mk(1, 1, 5,  0, 0,   1, 0, 3,  0, 2, 1, 0, 0);
    vecs[5]  = mk(1, 1, 7,  0, 0,   1, 0, 3,  0, 3, 1, 0, 0);
    vecs[6]  = mk(1, 1, 11, 0, 0,   0, 0, 3,  0, 4, 1, 0, 0); // full
    vecs[7]  = mk(1, 1, 12, 0, 0,   0, 0, 3,  0, 4, 1, 0, 0); // not ready: dropped
    vecs[8]  = mk(1, 1, 13, 1, 0,   1, 0, 9,  1, 3, 1, 0, 0); // pop while full, push blocked
    vecs[9]  = mk(1, 0, 0,  0, 0,   1, 0, 9,  0, 3, 1, 0, 0);
    vecs[10] = mk(1, 1, 6,  1, 0,   1, 0, 5,  1, 3, 1, 0, 0); // push+pop
    vecs[11] = mk(1, 0, 0,  1, 0,   1, 0, 7,  1, 2, 1, 0, 0);
    vecs[12] = mk(1, 1, 8,  1, 0,   1, 0, 11, 1, 2, 1, 0, 0); // push+pop at level 2
    vecs[13] = mk(1, 0, 0,  1, 0,   1, 0, 6,  1, 1, 1, 0, 0);
    vecs[14] = mk(1, 0, 0,  1, 0,   1, 0, 8,  1, 0, 1, 0, 0);
    vecs[15] = mk(1, 0, 0,  1, 0,   1, 0, 8,  1, 0, 1, 1, 1); // underrun
    vecs[16] = mk(1, 0, 0,  0, 0,   1, 0, 8,  0, 0, 1, 1, 1);
    vecs[17] = mk(1, 0, 0,  1, 0,   1, 0, 8,  1, 0, 1, 1, 2);
    vecs[18] = mk(1, 0, 0,  1, 0,   1, 0, 8,  1, 0, 1, 1, 3);
    vecs[19] = mk(1, 0, 0,  1, 0,   1, 0, 8,  1, 0, 1, 1, 3); // saturated
    vecs[20] = mk(1, 0, 0,  1, 0,   1, 0, 8,  1, 0, 1, 1, 3);
    vecs[21] = mk(1, 0, 0,  1, 1,   1, 0, 8,  1, 0, 1, 0, 0); // clear beats underrun
    vecs[22] = mk(1, 1, 2,  1, 0,   1, 0, 8,  1, 1, 1, 1, 1); // no bypass
    vecs[23] = mk(1, 0, 0,  0, 0,   1, 0, 8,  0, 1, 1, 1, 1);
    vecs[24] = mk(1, 0, 0,  1, 0,   1, 0, 2,  1, 0, 1, 1, 1);
    vecs[25] = mk(1, 1, 4,  0, 0,   1, 0, 2,  0, 1, 1, 1, 1);
    vecs[26] = mk(1, 1, 5,  0, 0,   1, 0, 2,  0, 2, 1, 1, 1);
    vecs[27] = mk(1, 1, 6,  0, 0,   1, 0, 2,  0, 3, 1, 1, 1);
    vecs[28] = mk(0, 1, 7,  1, 0,   0, 1, 0,  0, 0, 0, 1, 1); // disable: flush, keep underrun
    vecs[29] = mk(0, 0, 0,  0, 1,   0, 1, 0,  0, 0, 0, 0, 0);
    vecs[30] = mk(1, 1, 1,  0, 0,   1, 1, 0,  0, 0, 0, 0, 0); // IDLE: push ignored
    vecs[31] = mk(1, 1, 10, 0, 0,   1, 1, 0,  0, 1, 0, 0, 0);
    vecs[32] = mk(1, 1, 14, 0, 0,   1, 1, 0,  0, 2, 0, 0, 0);
    vecs[33] = mk(1, 0, 0,  0, 0,   1, 0, 10, 0, 1, 1, 0, 0); // old samples gone
    vecs[34] = mk(1, 0, 0,  1, 0,   1, 0, 14, 1, 0, 1, 0, 0);
    vecs[35] = mk(1, 0, 0,  1, 0,   1, 0, 14, 1, 0, 1, 1, 1);

    // Reset state.
    rst          = 1'b0;
    enable       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    pwm_eoc      = 1'b0;
    clr_underrun = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs(-1, 0, 1, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      enable       = vecs[i].en[0];
      sample_valid = vecs[i].vld[0];
      sample_data  = N'(vecs[i].dat);
      pwm_eoc      = vecs[i].eoc[0];
      clr_underrun = vecs[i].clr[0];
      @(posedge clk);
      #1;
      chk_outputs(i, vecs[i].rdy, vecs[i].prst, vecs[i].duty, vecs[i].stb,
                  vecs[i].lvl, vecs[i].run, vecs[i].und, vecs[i].cnt);
    end

    // Asynchronous reset mid-frame: outputs must drop before the next edge.
    @(negedge clk);
    pwm_eoc      = 1'b0;
    clr_underrun = 1'b0;
    sample_valid = 1'b1;
    sample_data  = 4'd3;
    #2;
    rst = 1'b0;
    #1;
    chk_outputs(100, 0, 1, 0, 0, 0, 0, 0, 0);
    // Reset held across an edge keeps everything parked.
    @(posedge clk);
    #1;
    chk_outputs(101, 0, 1, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
